// File: rtl/tc_sram_initiator_pkg.sv
// Shared types and helpers for the SRAM request initiator.
package tc_sram_initiator_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // Response buffering needed to sustain one read per cycle.
  function automatic int unsigned min_resp_depth(input int unsigned latency);
    return latency + 2;
  endfunction

endpackage

// File: rtl/tc_sram_initiator_fifo.sv
// Circular-buffer response FIFO; head entry is presented combinationally from registered storage.
module tc_sram_initiator_fifo
  import tc_sram_initiator_pkg::*;
#(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] rdata
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CntWidth'(Depth));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
    end
  end

endmodule

// File: rtl/tc_sram_initiator.sv
// Valid/ready to single-port SRAM initiator with credit-tracked reads and a response FIFO.
// Optional power-up zeroing sweep enabled by TC_SRAM_INITIATOR_INIT_EN.
module tc_sram_initiator
  import tc_sram_initiator_pkg::*;
#(
  parameter int unsigned NoWords   = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = min_resp_depth(Latency),
  parameter int unsigned AddrWidth = (NoWords > 1) ? $clog2(NoWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 busy_o
);

  localparam int unsigned CreditWidth = $clog2(RespDepth + 1);

`ifdef TC_SRAM_INITIATOR_INIT_EN
  localparam state_e ResetState = INIT;
`else
  localparam state_e ResetState = RUN;
`endif

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   init_addr_q, init_addr_d;
  logic [CreditWidth-1:0] credit_q;
  logic                   rd_accept, fifo_push, fifo_pop, fifo_full, fifo_empty;

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    req_ready_o  = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
    unique case (state_q)
      INIT: begin
        // Outputs are gated by rst_ni so nothing reaches the SRAM while reset is held.
        sram_req_o   = rst_ni;
        sram_we_o    = rst_ni;
        sram_addr_o  = init_addr_q;
        sram_wdata_o = '0;
        sram_be_o    = '1;
        if (init_addr_q == AddrWidth'(NoWords - 1)) state_d = RUN;
        else init_addr_d = init_addr_q + 1'b1;
      end
      RUN: begin
        req_ready_o = rst_ni && (req_we_i || (credit_q != '0));
        sram_req_o  = req_valid_i && req_ready_o;
        sram_we_o   = sram_req_o && req_we_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

`ifdef TC_SRAM_INITIATOR_INIT_EN
  assign busy_o = (state_q == INIT);
`else
  assign busy_o = 1'b0;
`endif

  assign rd_accept = sram_req_o && !sram_we_o;
  assign fifo_pop  = resp_valid_o && resp_ready_i;

  // A credit covers one read either in flight or parked in the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) credit_q <= CreditWidth'(RespDepth);
    else         credit_q <= credit_q - CreditWidth'(rd_accept) + CreditWidth'(fifo_pop);
  end

  generate
    if (Latency == 0) begin : g_lat0
      assign fifo_push = rd_accept;
    end else begin : g_lat
      logic [Latency-1:0] inflight_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= '0;
        else         inflight_q <= Latency'({inflight_q, rd_accept});
      end
      assign fifo_push = inflight_q[Latency-1];
    end
  endgenerate

  tc_sram_initiator_fifo #(
    .Depth(RespDepth),
    .Width(DataWidth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (sram_rdata_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (resp_rdata_o)
  );

  assign resp_valid_o = !fifo_empty;

  assert property (@(posedge clk_i) disable iff (!rst_ni) credit_q <= CreditWidth'(RespDepth));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(rd_accept && (credit_q == '0)));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Directed bench: instance A (Latency 1, depth 3) and instance B (Latency 0, depth 2), each with an SRAM model.
module tb_tc_sram_initiator;

  logic clk, rst_ni;
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_req_valid, a_req_ready, a_we, a_resp_valid, a_resp_ready;
  logic [3:0]  a_addr, a_be, a_sram_addr, a_sram_be;
  logic [31:0] a_wdata, a_resp_rdata, a_sram_wdata, a_sram_rdata;
  logic        a_sram_req, a_sram_we, a_busy;
  logic [31:0] mem_a [16];

  tc_sram_initiator #(
    .NoWords(16), .DataWidth(32), .ByteWidth(8), .Latency(1), .RespDepth(3)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_rdata_o(a_resp_rdata),
    .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
    .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata),
    .busy_o(a_busy)
  );

  // ---------------- instance B ----------------
  logic        b_req_valid, b_req_ready, b_we, b_resp_valid, b_resp_ready;
  logic [3:0]  b_addr, b_be, b_sram_addr, b_sram_be;
  logic [31:0] b_wdata, b_resp_rdata, b_sram_wdata, b_sram_rdata;
  logic        b_sram_req, b_sram_we, b_busy;
  logic [31:0] mem_b [16];

  tc_sram_initiator #(
    .NoWords(16), .DataWidth(32), .ByteWidth(8), .Latency(0), .RespDepth(2)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_rdata_o(b_resp_rdata),
    .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
    .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata),
    .busy_o(b_busy)
  );

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // SRAM models: A registers read data (latency 1), B reads combinationally (latency 0).
  always @(posedge clk) begin
    if (a_sram_req) begin
      if (a_sram_we) mem_a[a_sram_addr] <= merge_be(mem_a[a_sram_addr], a_sram_wdata, a_sram_be);
      else           a_sram_rdata <= mem_a[a_sram_addr];
    end
  end

  always @(posedge clk) begin
    if (b_sram_req && b_sram_we) mem_b[b_sram_addr] <= merge_be(mem_b[b_sram_addr], b_sram_wdata, b_sram_be);
  end
  assign b_sram_rdata = mem_b[b_sram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called with reset just released at a negedge.
  task automatic wait_init();
    int cnt;
    cnt = 0;
    #1;
`ifdef TC_SRAM_INITIATOR_INIT_EN
    while (a_busy && cnt < 40) begin
      check("sweep_addr", {28'd0, a_sram_addr}, cnt);
      check("sweep_wr", {28'd0, a_sram_req, a_sram_we, (a_sram_wdata == 32'd0), (a_sram_be == 4'hF)}, 32'hF);
      cnt++;
      @(negedge clk);
      #1;
    end
    check("sweep_len", cnt, 16);
`else
    check("busy_off", {31'd0, a_busy}, 0);
`endif
    check("b_busy_done", {31'd0, b_busy}, 0);
    check("ready_after_init", {31'd0, a_req_ready}, 1);
  endtask

  task automatic a_xact(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic [1:0] seen,
                        output bit ok);
    int n;
    ok = 0; rd = '0; seen = '0;
    @(negedge clk);
    a_req_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    #1;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!a_req_ready) begin a_req_valid = 1'b0; return; end
    seen = {a_sram_req, a_sram_we};
    @(negedge clk);
    a_req_valid = 1'b0;
    if (we) begin ok = 1; return; end
    n = 0;
    while (!a_resp_valid && n < 20) begin @(negedge clk); n++; end
    if (a_resp_valid) begin rd = a_resp_rdata; ok = 1; end
  endtask

  // Hold a read request for a number of cycles with the consumer stalled; returns how many were taken.
  task automatic stalled_reads(input int cycles, output int acc);
    acc = 0;
    a_resp_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_we = 1'b0; a_addr = 4'(1 + acc);
      #1;
      if (a_req_ready) acc++;
    end
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  seen;
    bit          ok;
    int          acc, n;
    logic [31:0] bp_exp [3];

    vecs[0]  = '{1'b1, 4'd5, 32'hA5A5A5A5, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 4'd5, 32'h0,        4'hF, 32'hA5A5A5A5};
    vecs[2]  = '{1'b1, 4'd7, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 4'd7, 32'h11223344, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 4'd7, 32'h0,        4'hF, 32'hFF22FF44};
    vecs[5]  = '{1'b1, 4'd1, 32'h01010101, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 4'd2, 32'h02020202, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 4'd3, 32'h03030303, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, 4'd4, 32'h04040404, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 4'd1, 32'h0,        4'hF, 32'h01010101};
    vecs[10] = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hC, 32'h0};
    vecs[11] = '{1'b0, 4'd3, 32'h0,        4'hF, 32'hAABB0303};
    vecs[12] = '{1'b0, 4'd2, 32'h0,        4'hF, 32'h02020202};
    bp_exp[0] = 32'h01010101; bp_exp[1] = 32'h02020202; bp_exp[2] = 32'hAABB0303;

    rst_ni = 1'b0;
    a_req_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_resp_ready = 1;
    b_req_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_resp_ready = 1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", {31'd0, a_req_ready}, 0);
    check("rst_resp_valid", {31'd0, a_resp_valid}, 0);
    check("rst_sram_req_we", {30'd0, a_sram_req, a_sram_we}, 0);
`ifdef TC_SRAM_INITIATOR_INIT_EN
    check("rst_busy", {31'd0, a_busy}, 1);
`else
    check("rst_busy", {31'd0, a_busy}, 0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    wait_init();

`ifdef TC_SRAM_INITIATOR_INIT_EN
    a_xact(1'b0, 4'd9, 32'h0, 4'hF, rd, seen, ok);
    check("sweep_read9_ok", {31'd0, ok}, 1);
    check("sweep_read9", rd, 32'h0);
`endif

    // Table-driven single transactions
    for (int i = 0; i < 13; i++) begin
      a_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, seen, ok);
      check("vec_done", {31'd0, ok}, 1);
      check("vec_sram_req_we", {30'd0, seen}, {30'd0, 1'b1, vecs[i].we});
      if (!vecs[i].we) check("vec_rdata", rd, vecs[i].exp);
      $display("vec %0d we=%0d addr=%0d data=%h", i, vecs[i].we, vecs[i].addr, vecs[i].we ? vecs[i].wdata : rd);
    end

    // Back-to-back reads of address 5
    a_resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 9) begin
        check("b2b_valid", {31'd0, a_resp_valid}, 1);
        check("b2b_data", a_resp_rdata, 32'hA5A5A5A5);
      end else begin
        check("b2b_idle", {31'd0, a_resp_valid}, 0);
      end
      a_req_valid = (i < 8); a_we = 1'b0; a_addr = 4'd5;
      if (i < 8) begin #1; check("b2b_ready", {31'd0, a_req_ready}, 1); end
    end
    a_req_valid = 1'b0;
    $display("b2b 8 reads addr=5 done");

    // Backpressure: only RespDepth reads taken, then drained in order
    stalled_reads(6, acc);
    check("bp_accepted", acc, 3);
    #1;
    check("bp_blocked", {31'd0, a_req_ready}, 0);
    a_resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!a_resp_valid && n < 10) begin @(negedge clk); n++; end
      check("bp_valid", {31'd0, a_resp_valid}, 1);
      check("bp_data", a_resp_rdata, bp_exp[k]);
      @(negedge clk);
    end
    check("bp_empty", {31'd0, a_resp_valid}, 0);
    $display("backpressure accepted=%0d drained=3", acc);

    // Zero latency on instance B
    @(negedge clk);
    b_req_valid = 1'b1; b_we = 1'b1; b_addr = 4'd3; b_wdata = 32'h12345678; b_be = 4'hF;
    #1;
    check("z_wr_ready", {31'd0, b_req_ready}, 1);
    check("z_wr_sram", {30'd0, b_sram_req, b_sram_we}, 3);
    @(negedge clk);
    b_we = 1'b0;
    #1;
    check("z_rd_ready", {31'd0, b_req_ready}, 1);
    check("z_rd_sram", {30'd0, b_sram_req, b_sram_we}, 2);
    check("z_not_yet", {31'd0, b_resp_valid}, 0);
    @(negedge clk);
    b_req_valid = 1'b0;
    check("z_valid", {31'd0, b_resp_valid}, 1);
    check("z_data", b_resp_rdata, 32'h12345678);
    #1;
    check("z_idle_sram", {30'd0, b_sram_req, b_sram_we}, 0);
    @(negedge clk);
    check("z_popped", {31'd0, b_resp_valid}, 0);
    $display("zero-latency write/read addr=3 data=%h", 32'h12345678);

    // Reset with two reads in flight
    a_resp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    @(negedge clk);
    a_addr = 4'd2;
    @(negedge clk);
    a_req_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, a_resp_valid}, 0);
    check("mid_rst_ready", {31'd0, a_req_ready}, 0);
    check("mid_rst_sram", {30'd0, a_sram_req, a_sram_we}, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    wait_init();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_resp", {31'd0, a_resp_valid}, 0);
    end
    stalled_reads(6, acc);
    check("mid_rst_credit", acc, 3);
    a_resp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("final_empty", {31'd0, a_resp_valid}, 0);
    $display("reset mid-operation accepted_after=%0d", acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
